// File: rtl/mem_bist_seq_pkg.sv
// Shared constants, state encoding and pattern generator for the memory BIST sequencer.
// MEM_BIST_INVERT_PASS_EN adds the pass-index type used by the second, inverted-pattern pass.
package mem_bist_pkg;

    localparam int unsigned ADDR_W       = 32;
    localparam logic [7:0]  SEED_DEFAULT = 8'hA5;
    localparam int unsigned PAT_MAX_W    = 256;

    typedef logic [2:0] bist_state_t;

    localparam bist_state_t ST_IDLE  = 3'd0;
    localparam bist_state_t ST_WRITE = 3'd1;
    localparam bist_state_t ST_READ  = 3'd2;
    localparam bist_state_t ST_DRAIN = 3'd3;
    localparam bist_state_t ST_DONE  = 3'd4;

`ifdef MEM_BIST_INVERT_PASS_EN
    typedef logic bist_pass_t;

    localparam bist_pass_t PASS_TRUE = 1'b0;
    localparam bist_pass_t PASS_INV  = 1'b1;
`endif

    // Callers truncate to their word width; the low byte repeats, so truncation keeps the
    // partial upper copy aligned.
    function automatic logic [PAT_MAX_W-1:0] bist_pattern(input logic [ADDR_W-1:0] a,
                                                          input logic [7:0]        seed);
        logic [7:0] b;
        b = a[7:0] ^ seed;
        return {(PAT_MAX_W / 8){b}};
    endfunction

endpackage

// File: rtl/mem_bist_seq_if.sv
// Control, status and RAM-port bundle between the BIST sequencer and its environment.
interface mem_bist_seq_if #(
    parameter int unsigned WID_MEM = 8,
    parameter int unsigned ERR_W   = 16
);

    logic                              start;
    logic [mem_bist_pkg::ADDR_W-1:0]   raddr;
    logic [mem_bist_pkg::ADDR_W-1:0]   waddr;
    logic [WID_MEM-1:0]                din;
    logic [WID_MEM-1:0]                dout;
    logic                              busy;
    logic                              done;
    logic                              pass;
    logic [ERR_W-1:0]                  err_count;
    logic [mem_bist_pkg::ADDR_W-1:0]   first_err_addr;

    modport master (
        input  start,
        input  dout,
        output raddr,
        output waddr,
        output din,
        output busy,
        output done,
        output pass,
        output err_count,
        output first_err_addr
    );

    modport slave (
        output start,
        output dout,
        input  raddr,
        input  waddr,
        input  din,
        input  busy,
        input  done,
        input  pass,
        input  err_count,
        input  first_err_addr
    );

endinterface

// File: rtl/mem_bist_seq_cmp.sv
// Read-side checker: aligns expected word and address with RAM output, counts mismatches
// with saturation and captures the address of the first one.
module mem_bist_cmp
    import mem_bist_pkg::*;
#(
    parameter int unsigned WID_MEM = 8,
    parameter int unsigned ERR_W   = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                rd_valid,
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [WID_MEM-1:0]  rd_exp,
    input  logic [WID_MEM-1:0]  dout,
    output logic [ERR_W-1:0]    err_count,
    output logic [ADDR_W-1:0]   first_err_addr
);

    logic                valid_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [WID_MEM-1:0]  exp_q;
    logic                mismatch;
    logic [ERR_W-1:0]    err_q, err_d;
    logic [ADDR_W-1:0]   first_q, first_d;

    // Loaded on the edge the RAM samples raddr, so they line up with dout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            exp_q   <= '0;
        end else begin
            valid_q <= rd_valid;
            addr_q  <= rd_addr;
            exp_q   <= rd_exp;
        end
    end

    assign mismatch = valid_q && (dout != exp_q);

    always_comb begin
        err_d   = err_q;
        first_d = first_q;
        if (clear) begin
            err_d   = '0;
            first_d = '0;
        end else if (mismatch) begin
            // The counter saturates, so zero reliably marks "no mismatch seen yet".
            if (err_q == '0) begin
                first_d = addr_q;
            end
            if (err_q != '1) begin
                err_d = err_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q   <= '0;
            first_q <= '0;
        end else begin
            err_q   <= err_d;
            first_q <= first_d;
        end
    end

    assign err_count      = err_q;
    assign first_err_addr = first_q;

endmodule

// File: rtl/mem_bist_seq.sv
// BIST sequencer: fills the attached dual-port RAM with a seeded pattern, reads it back and
// checks it. MEM_BIST_INVERT_PASS_EN adds a second pass with the inverted pattern.
module mem_bist_seq
    import mem_bist_pkg::*;
#(
    parameter int unsigned WID_MEM   = 8,
    parameter int unsigned DEPTH_MEM = 2048,
    parameter logic [7:0]  SEED      = SEED_DEFAULT,
    parameter int unsigned ERR_W     = 16
) (
    input  logic           clk,
    input  logic           reset,
    mem_bist_seq_if.master bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH_MEM - 1);
    localparam logic [ADDR_W-1:0] WR_END    = ADDR_W'(DEPTH_MEM);

    function automatic logic [WID_MEM-1:0] word_for(input logic [ADDR_W-1:0] a,
                                                    input logic              invert);
        return WID_MEM'(bist_pattern(a, SEED)) ^ {WID_MEM{invert}};
    endfunction

    localparam logic [WID_MEM-1:0] DIN_RST = WID_MEM'(bist_pattern('0, SEED));

    bist_state_t          state_q, state_d;
    logic [ADDR_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]    waddr_q, waddr_d;
    logic [ADDR_W-1:0]    raddr_q, raddr_d;
    logic [WID_MEM-1:0]   din_q, din_d;
    logic                 accept;
    logic                 inv;
    logic [ERR_W-1:0]     err_count;
    logic [ADDR_W-1:0]    first_err_addr;

`ifdef MEM_BIST_INVERT_PASS_EN
    bist_pass_t pass_idx_q, pass_idx_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pass_idx_q <= PASS_TRUE;
        end else begin
            pass_idx_q <= pass_idx_d;
        end
    end

    assign inv = (pass_idx_q == PASS_INV);
`else
    assign inv = 1'b0;
`endif

    // WRITE spends one extra cycle at cnt == DEPTH so the RAM commits the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        din_d   = din_q;
        accept  = 1'b0;
`ifdef MEM_BIST_INVERT_PASS_EN
        pass_idx_d = pass_idx_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = ST_WRITE;
                    cnt_d   = '0;
`ifdef MEM_BIST_INVERT_PASS_EN
                    pass_idx_d = PASS_TRUE;
`endif
                end
            end
            ST_WRITE: begin
                if (cnt_q == WR_END) begin
                    state_d = ST_READ;
                    raddr_d = '0;
                end else begin
                    waddr_d = cnt_q;
                    din_d   = word_for(cnt_q, inv);
                    cnt_d   = cnt_q + 32'd1;
                end
            end
            ST_READ: begin
                if (raddr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                end else begin
                    raddr_d = raddr_q + 32'd1;
                end
            end
            ST_DRAIN: begin
`ifdef MEM_BIST_INVERT_PASS_EN
                if (pass_idx_q == PASS_TRUE) begin
                    state_d    = ST_WRITE;
                    cnt_d      = '0;
                    pass_idx_d = PASS_INV;
                end else begin
                    state_d = ST_DONE;
                end
`else
                state_d = ST_DONE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            waddr_q <= '0;
            raddr_q <= '0;
            din_q   <= DIN_RST;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            din_q   <= din_d;
        end
    end

    mem_bist_cmp #(
        .WID_MEM (WID_MEM),
        .ERR_W   (ERR_W)
    ) u_cmp (
        .clk            (clk),
        .reset          (reset),
        .clear          (accept),
        .rd_valid       (state_q == ST_READ),
        .rd_addr        (raddr_q),
        .rd_exp         (word_for(raddr_q, inv)),
        .dout           (bus.dout),
        .err_count      (err_count),
        .first_err_addr (first_err_addr)
    );

    assign bus.waddr          = waddr_q;
    assign bus.raddr          = raddr_q;
    assign bus.din            = din_q;
    assign bus.busy           = (state_q == ST_WRITE) || (state_q == ST_READ) ||
                                (state_q == ST_DRAIN);
    assign bus.done           = (state_q == ST_DONE);
    assign bus.pass           = (state_q == ST_DONE) && (err_count == '0);
    assign bus.err_count      = err_count;
    assign bus.first_err_addr = first_err_addr;

endmodule

// File: tb/tb_mem_bist_seq.sv
// Directed bench for mem_bist_seq on a 16x8 RAM model with injectable read faults.
// Expectations follow MEM_BIST_INVERT_PASS_EN when it is defined for the build.
module tb_mem_bist_seq;

    localparam int unsigned WID   = 8;
    localparam int unsigned DEPTH = 16;
`ifdef MEM_BIST_INVERT_PASS_EN
    localparam int unsigned EW        = 2;
    localparam int unsigned NPASS     = 2;
    localparam logic [7:0]  RAM5_EXP  = 8'h5F;
    localparam logic [7:0]  DIN_LAST  = 8'h55;
`else
    localparam int unsigned EW        = 16;
    localparam int unsigned NPASS     = 1;
    localparam logic [7:0]  RAM5_EXP  = 8'hA0;
    localparam logic [7:0]  DIN_LAST  = 8'hAA;
`endif
    localparam int unsigned DONE_EDGE = NPASS * (2 * DEPTH + 2);
    localparam int unsigned ERR_MAX   = (1 << EW) - 1;
    localparam int          LIMIT     = 200;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   fault_mode = 0;
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   edge_seen;

    logic [WID-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    mem_bist_seq_if #(.WID_MEM(WID), .ERR_W(EW)) bus ();

    mem_bist_seq #(
        .WID_MEM   (WID),
        .DEPTH_MEM (DEPTH),
        .SEED      (8'hA5),
        .ERR_W     (EW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // 0: clean, 1: bit0 flip at 9, 2: stuck-at-zero at 3 and 12, 3: every read inverted.
    function automatic logic [WID-1:0] rd_fault(input logic [WID-1:0] w, input logic [31:0] a,
                                                input int mode);
        case (mode)
            1:       return (a == 32'd9) ? (w ^ 8'h01) : w;
            2:       return ((a == 32'd3) || (a == 32'd12)) ? 8'h00 : w;
            3:       return ~w;
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        mem[bus.waddr[3:0]] <= bus.din;
        bus.dout            <= rd_fault(mem[bus.raddr[3:0]], bus.raddr, fault_mode);
    end

    function automatic int unsigned sat(input int unsigned n);
        return (n > ERR_MAX) ? ERR_MAX : n;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    // Edge 0 is the one that samples start; returns the first edge after which done is high.
    task automatic run(input string name, input int restart_edge, output int done_edge);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        check({name, " busy after start"}, 64'(bus.busy), 64'd1);
        check({name, " done cleared"}, 64'(bus.done), 64'd0);
        done_edge = -1;
        for (int k = 1; k <= LIMIT; k++) begin
            if (k == restart_edge) begin
                @(negedge clk);
                bus.start = 1'b1;
                @(posedge clk);
                #1 bus.start = 1'b0;
            end else begin
                @(posedge clk);
                #1;
            end
            if (bus.done) begin
                done_edge = k;
                break;
            end
        end
        check({name, " done edge"}, 64'(done_edge), 64'(DONE_EDGE));
    endtask

    task automatic check_reset_state(input string name);
        check({name, " busy"}, 64'(bus.busy), 64'd0);
        check({name, " done"}, 64'(bus.done), 64'd0);
        check({name, " pass"}, 64'(bus.pass), 64'd0);
        check({name, " err_count"}, 64'(bus.err_count), 64'd0);
        check({name, " first_err_addr"}, 64'(bus.first_err_addr), 64'd0);
        check({name, " waddr"}, 64'(bus.waddr), 64'd0);
        check({name, " raddr"}, 64'(bus.raddr), 64'd0);
        check({name, " din"}, 64'(bus.din), 64'hA5);
    endtask

    initial begin
        bus.start = 1'b0;
        #12;
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b1;

        // Clean memory
        fault_mode = 0;
        run("clean", 0, edge_seen);
        check("clean pass", 64'(bus.pass), 64'd1);
        check("clean err_count", 64'(bus.err_count), 64'd0);
        check("clean first_err_addr", 64'(bus.first_err_addr), 64'd0);
        check("clean busy", 64'(bus.busy), 64'd0);
        check("clean ram5", 64'(mem[5]), 64'(RAM5_EXP));
        repeat (3) @(posedge clk);
        #1;
        check("idle done sticky", 64'(bus.done), 64'd1);
        check("idle waddr hold", 64'(bus.waddr), 64'd15);
        check("idle din hold", 64'(bus.din), 64'(DIN_LAST));
        check("idle raddr hold", 64'(bus.raddr), 64'd15);

        // Single bit flip at address 9
        fault_mode = 1;
        run("flip9", 0, edge_seen);
        check("flip9 pass", 64'(bus.pass), 64'd0);
        check("flip9 err_count", 64'(bus.err_count), 64'(sat(NPASS)));
        check("flip9 first_err_addr", 64'(bus.first_err_addr), 64'd9);

        // Stuck-at-zero at addresses 3 and 12
        fault_mode = 2;
        run("stuck", 0, edge_seen);
        check("stuck pass", 64'(bus.pass), 64'd0);
        check("stuck err_count", 64'(bus.err_count), 64'(sat(2 * NPASS)));
        check("stuck first_err_addr", 64'(bus.first_err_addr), 64'd3);

        // Every read corrupted
        fault_mode = 3;
        run("all", 0, edge_seen);
        check("all pass", 64'(bus.pass), 64'd0);
        check("all err_count", 64'(bus.err_count), 64'(sat(DEPTH * NPASS)));
        check("all first_err_addr", 64'(bus.first_err_addr), 64'd0);

        // Reset mid-WRITE, then a clean run
        fault_mode = 0;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_reset_state("abort");
        @(negedge clk);
        reset = 1'b1;
        run("after abort", 0, edge_seen);
        check("after abort pass", 64'(bus.pass), 64'd1);
        check("after abort err_count", 64'(bus.err_count), 64'd0);

        // Second start while busy is dropped
        run("restart", 8, edge_seen);
        check("restart pass", 64'(bus.pass), 64'd1);
        @(posedge clk);
        #1;
        check("restart stays done", 64'(bus.done), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
